// File: rtl/uart_rffe_cmd_sequencer.sv
// uart_rffe_cmd_sequencer: validates a latched UART burst and replays its embedded commands onto the RFFE master
module uart_rffe_cmd_sequencer #(
  parameter int DATA_DEPTH     = 36,
  parameter int MAX_CMDS       = 11,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_DEPTH*8-1:0] rx_data,
  input  logic [5:0]              rx_bytes,
  input  logic                    rx_check_all,
  input  logic                    rx_irq,
  output logic                    rx_irq_clear,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [1:0]              cmd_op,
  output logic [3:0]              cmd_usid,
  output logic [7:0]              cmd_addr,
  output logic [7:0]              cmd_wdata,
  input  logic                    rsp_valid,
  input  logic                    rsp_err,
  input  logic [7:0]              rsp_rdata,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              status,
  output logic [MAX_CMDS*8-1:0]   rd_data,
  output logic [3:0]              rd_count
);
  localparam int DW = DATA_DEPTH*8;
  localparam int RW = MAX_CMDS*8;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_RSP, DONE} state_t;
  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [5:0]      bytes_q, bytes_d;
  logic            chk_q, chk_d;
  logic [3:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rd_data_q, rd_data_d;
  logic [3:0]      rd_count_q, rd_count_d;
  logic [2:0]      status_q, status_d;
  logic [7:0]      n, cmd_a, cmd_b, cmd_c;
  logic [1:0]      op;
  logic [2:0]      chk_err;
  function automatic logic [7:0] byte_at(input logic [DW-1:0] d, input int k);
    return d[DW-1-8*k -: 8];
  endfunction
  always_comb begin
    n = byte_at(data_q, 1);
    cmd_a = byte_at(data_q, 2 + 3*int'(idx_q));
    cmd_b = byte_at(data_q, 3 + 3*int'(idx_q));
    cmd_c = byte_at(data_q, 4 + 3*int'(idx_q));
    op = 2'(cmd_a >> 6);
    chk_err = !chk_q ? 3'd1 :
              byte_at(data_q, 0) != 8'hA5 ? 3'd2 :
              (n == 8'd0 || int'(n) > MAX_CMDS || int'(bytes_q) != 2 + 3*int'(n)) ? 3'd3 : 3'd0;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IDLE;
      data_q <= '0;
      bytes_q <= '0;
      chk_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= '0;
      rd_data_q <= '0;
      rd_count_q <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      bytes_q <= bytes_d;
      chk_q <= chk_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_count_q <= rd_count_d;
      status_q <= status_d;
    end
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    bytes_d = bytes_q;
    chk_d = chk_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    rd_data_d = rd_data_q;
    rd_count_d = rd_count_q;
    status_d = status_q;
    case (state_q)
      IDLE: if (rx_irq) begin
        state_d = CHECK;
        data_d = rx_data;
        bytes_d = rx_bytes;
        chk_d = rx_check_all;
        idx_d = '0;
        rd_data_d = '0;
        rd_count_d = '0;
      end
      CHECK: begin
        state_d = chk_err != 3'd0 ? DONE : ISSUE;
        status_d = chk_err != 3'd0 ? chk_err : status_q;
      end
      ISSUE: if (op == 2'b11) begin
        state_d = DONE;
        status_d = 3'd4;
      end else if (cmd_ready) begin
        state_d = WAIT_RSP;
        cnt_d = '0;
      end
      WAIT_RSP: if (rsp_valid && rsp_err) begin
        state_d = DONE;
        status_d = 3'd6;
      end else if (rsp_valid) begin
        rd_data_d = op == 2'b10 ? {rd_data_q[RW-9:0], rsp_rdata} : rd_data_q;
        rd_count_d = op == 2'b10 ? rd_count_q + 4'd1 : rd_count_q;
        state_d = int'(idx_q) == int'(n) - 1 ? DONE : ISSUE;
        status_d = int'(idx_q) == int'(n) - 1 ? 3'd0 : status_q;
        idx_d = idx_q + 4'd1;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 2)) begin
        state_d = DONE;
        status_d = 3'd5;
      end else cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  // cmd_valid is gated by rst so a reset drops the request in the same cycle
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
    rx_irq_clear = state_q == CHECK;
    cmd_valid = rst && state_q == ISSUE && op != 2'b11;
    cmd_op = state_q == ISSUE ? op : 2'b00;
    cmd_usid = state_q == ISSUE ? 4'(cmd_a) : 4'd0;
    cmd_addr = state_q == ISSUE ? cmd_b : 8'd0;
    cmd_wdata = state_q == ISSUE ? cmd_c : 8'd0;
    status = status_q;
    rd_data = rd_data_q;
    rd_count = rd_count_q;
  end
endmodule

// File: tb/tb_uart_rffe_cmd_sequencer.sv
// tb_uart_rffe_cmd_sequencer: randomized packets and RFFE responses checked against a packet-level model
module tb_uart_rffe_cmd_sequencer;
  localparam int DD = 36;
  localparam int MC = 11;
  localparam int TO = 16;
  logic clk = 0, rst = 0;
  logic [DD*8-1:0] rx_data = '0;
  logic [5:0] rx_bytes = '0;
  logic rx_check_all = 0, rx_irq = 0, rx_irq_clear;
  logic cmd_valid, cmd_ready = 0;
  logic [1:0] cmd_op;
  logic [3:0] cmd_usid;
  logic [7:0] cmd_addr, cmd_wdata;
  logic rsp_valid = 0, rsp_err = 0;
  logic [7:0] rsp_rdata = '0;
  logic busy, done;
  logic [2:0] status;
  logic [MC*8-1:0] rd_data;
  logic [3:0] rd_count;
  logic [7:0] pkt [DD];
  int stall [MC], dly [MC];
  bit err [MC], drop [MC];
  logic [7:0] rdv [MC];
  int exp_st, exp_nx, exp_cnt;
  logic [MC*8-1:0] exp_rd;
  int total = 0, bad = 0;
  uart_rffe_cmd_sequencer #(.DATA_DEPTH(DD), .MAX_CMDS(MC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_bytes(rx_bytes), .rx_check_all(rx_check_all),
    .rx_irq(rx_irq), .rx_irq_clear(rx_irq_clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_usid(cmd_usid), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy), .done(done),
    .status(status), .rd_data(rd_data), .rd_count(rd_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set_cmd(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    pkt[2+3*i] = a;
    pkt[3+3*i] = b;
    pkt[4+3*i] = c;
  endtask
  task automatic clear_plan();
    for (int i = 0; i < MC; i++) begin
      stall[i] = 0;
      dly[i] = 2;
      err[i] = 0;
      drop[i] = 0;
      rdv[i] = 8'($urandom);
    end
  endtask
  // expected outcome: walk the packet command by command using the planned responses
  task automatic model(input int nb, input bit ck);
    int n;
    n = pkt[1];
    exp_nx = 0;
    exp_rd = '0;
    exp_cnt = 0;
    if (!ck) exp_st = 1;
    else if (pkt[0] != 8'hA5) exp_st = 2;
    else if (n == 0 || n > MC || nb != 2 + 3*n) exp_st = 3;
    else begin
      exp_st = 0;
      for (int i = 0; i < n; i++) begin
        if (pkt[2+3*i][7:6] == 2'b11) begin exp_st = 4; break; end
        exp_nx++;
        if (drop[i]) begin exp_st = 5; break; end
        if (err[i]) begin exp_st = 6; break; end
        if (pkt[2+3*i][7:6] == 2'b10) begin
          exp_rd = {exp_rd[MC*8-9:0], rdv[i]};
          exp_cnt++;
        end
      end
    end
  endtask
  task automatic load(input int nb, input bit ck);
    logic [DD*8-1:0] d;
    for (int k = 0; k < DD; k++) d[DD*8-1-8*k -: 8] = pkt[k];
    rx_data = d;
    rx_bytes = 6'(nb);
    rx_check_all = ck;
    rx_irq = 1;
  endtask
  task automatic run(input int nb, input bit ck);
    int cyc = 0, xf = 0, sc = 0, rc = -1, since = -1;
    bit fin = 0, just = 0;
    model(nb, ck);
    load(nb, ck);
    @(negedge clk);
    chk("irq_clear", rx_irq_clear, 1);
    chk("busy_start", busy, 1);
    rx_irq = 0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      cmd_ready = 0;
      rsp_valid = 0;
      rsp_err = 0;
      if (since >= 0) since++;
      chk("clear_once", rx_irq_clear, 0);
      if (just) chk("valid_drop", cmd_valid, 0);
      just = 0;
      if (done) begin
        chk("status", status, exp_st);
        chk("rd_count", rd_count, exp_cnt);
        chk("rd_data", rd_data, exp_rd);
        chk("xfers", xf, exp_nx);
        chk("busy_done", busy, 1);
        if (exp_st >= 1 && exp_st <= 3) chk("check_lat", cyc, 1);
        if (exp_st == 5) chk("timeout_lat", since, TO);
        fin = 1;
      end else begin
        if (rc == 0 && !drop[xf-1]) begin
          rsp_valid = 1;
          rsp_err = err[xf-1];
          rsp_rdata = rdv[xf-1];
        end
        if (rc >= 0) rc--;
        if (cmd_valid) begin
          if (xf >= exp_nx) chk("extra_cmd", xf, exp_nx);
          else begin
            chk("op", cmd_op, pkt[2+3*xf][7:6]);
            chk("usid", cmd_usid, pkt[2+3*xf][3:0]);
            chk("addr", cmd_addr, pkt[3+3*xf]);
            if (pkt[2+3*xf][7:6] != 2'b10) chk("wdata", cmd_wdata, pkt[4+3*xf]);
            rsp_valid = 1'($urandom);
            rsp_err = 1;
            if (sc < stall[xf]) sc++;
            else begin
              cmd_ready = 1;
              sc = 0;
              xf++;
              rc = dly[xf-1];
              since = 0;
              just = 1;
            end
          end
        end
      end
    end
    if (!fin) chk("done_seen", 0, 1);
    cmd_ready = 0;
    rsp_valid = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("done_pulse", done, 0);
    chk("hold_count", rd_count, exp_cnt);
  endtask
  task automatic reset_mid(input bit in_issue);
    int w = 0;
    clear_plan();
    pkt[0] = 8'hA5;
    pkt[1] = 8'd1;
    set_cmd(0, 8'h81, 8'h1C, 8'h00);
    load(5, 1);
    @(negedge clk);
    rx_irq = 0;
    while (!cmd_valid && w < 10) begin @(negedge clk); w++; end
    chk("rst_reach", cmd_valid, 1);
    if (in_issue) begin
      rst = 0;
      #1 chk("rst_valid_now", cmd_valid, 0);
    end else begin
      cmd_ready = 1;
      @(negedge clk);
      cmd_ready = 0;
      @(negedge clk);
      rst = 0;
    end
    @(negedge clk);
    chk("rst_outs", {rx_irq_clear, cmd_valid, cmd_op, cmd_usid, cmd_addr, cmd_wdata, busy, done, status, rd_count}, 0);
    chk("rst_rd", rd_data, 0);
    rst = 1;
    @(negedge clk);
  endtask
  initial begin
    for (int k = 0; k < DD; k++) pkt[k] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outs", {rx_irq_clear, cmd_valid, cmd_op, cmd_usid, cmd_addr, cmd_wdata, busy, done, status, rd_count}, 0);
    chk("reset_rd", rd_data, 0);
    rst = 1;
    @(negedge clk);
    clear_plan();
    pkt[0] = 8'hA5; pkt[1] = 8'd1; set_cmd(0, 8'h81, 8'h1C, 8'h00);
    dly[0] = 2; rdv[0] = 8'h5A;
    run(5, 1);
    clear_plan();
    pkt[1] = 8'd3; set_cmd(0, 8'h42, 8'h10, 8'h99); set_cmd(1, 8'h83, 8'h20, 8'h00); set_cmd(2, 8'h85, 8'h30, 8'h00);
    stall[1] = 5; rdv[1] = 8'h11; rdv[2] = 8'h22; dly[2] = TO - 2;
    run(11, 1);
    pkt[0] = 8'h55;
    run(11, 1);
    pkt[0] = 8'hA5; pkt[1] = 8'd2;
    run(7, 1);
    pkt[1] = 8'd3;
    run(11, 0);
    clear_plan();
    pkt[1] = 8'd2; set_cmd(0, 8'h41, 8'h05, 8'h77); set_cmd(1, 8'hC3, 8'h06, 8'h00);
    run(8, 1);
    clear_plan();
    pkt[1] = 8'd1; set_cmd(0, 8'h81, 8'h1C, 8'h00); drop[0] = 1;
    run(5, 1);
    clear_plan();
    pkt[1] = 8'd3; set_cmd(0, 8'h82, 8'h01, 8'h00); set_cmd(1, 8'h42, 8'h02, 8'h03); set_cmd(2, 8'h82, 8'h04, 8'h00);
    err[0] = 1;
    run(11, 1);
    reset_mid(0);
    reset_mid(1);
    clear_plan();
    pkt[0] = 8'hA5; pkt[1] = 8'd1; set_cmd(0, 8'h81, 8'h1C, 8'h00); rdv[0] = 8'hC4;
    run(5, 1);
    repeat (40) begin
      int n, nb, r;
      bit ck;
      n = $urandom_range(1, MC);
      nb = 2 + 3*n;
      ck = 1;
      pkt[0] = 8'hA5;
      pkt[1] = 8'(n);
      for (int i = 0; i < MC; i++) begin
        r = $urandom_range(0, 19);
        set_cmd(i, {(r == 0) ? 2'b11 : 2'(r % 3), 2'b00, 4'($urandom)}, 8'($urandom), 8'($urandom));
        stall[i] = $urandom_range(0, 3);
        dly[i] = $urandom_range(0, TO - 2);
        err[i] = ($urandom_range(0, 24) == 0);
        drop[i] = ($urandom_range(0, 39) == 0);
        rdv[i] = 8'($urandom);
      end
      r = $urandom_range(0, 9);
      if (r == 0) ck = 0;
      if (r == 1) pkt[0] = 8'($urandom);
      if (r == 2) nb = $urandom_range(0, 35);
      if (r == 3) pkt[1] = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(12, 255));
      run(nb, ck);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
